// File: rtl/obsidian_hazard_scoreboard.sv
// Hazard scoreboard for the Obsidian 5-stage pipeline: per-register pending-write
// counters fed by Decode issues and WB_ID retires, producing the Decode stall.
module obsidian_hazard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             err
);
  logic [CNT_W-1:0] cnt_nxt;

  // A retire against an empty counter is a bookkeeping error, unless flush drops it.
  assign err = dec & ~flush & (cnt == '0);

  always_comb begin
    cnt_nxt = cnt;
    if (flush)                         cnt_nxt = '0;
    else if (inc & ~dec)               cnt_nxt = cnt + 1'b1;
    else if (dec & ~inc & (cnt != '0)) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= |cnt_nxt;
    end
  end
endmodule

module obsidian_hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rs1,
  input  logic [4:0]        iss_rs2,
  input  logic              iss_use_rs1,
  input  logic              iss_use_rs2,
  input  logic              iss_wr,
  input  logic [4:0]        iss_rd,
  input  logic [37:0]       WB_ID,
  input  logic              flush,
  output logic              stall,
  output logic [NREGS-1:0]  busy_map,
  output logic              retire_err,
  output logic [PERF_W-1:0] stall_cycles
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             BYP_EN  = (WB_BYPASS != 0);

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            err_vec;
  logic [4:0]                  ret_rd;
  logic                        ret, byp1, byp2, hz1, hz2, sat, inc_any;
  logic                        unused_wb_data;

  assign ret_rd         = WB_ID[36:32];
  assign ret            = WB_ID[37] & (ret_rd != '0);
  assign unused_wb_data = ^WB_ID[31:0];

  // The last pending write retiring this cycle is visible to the reader right away.
  assign byp1 = BYP_EN & ret & (ret_rd == iss_rs1) & (cnt[iss_rs1] == CNT_ONE);
  assign byp2 = BYP_EN & ret & (ret_rd == iss_rs2) & (cnt[iss_rs2] == CNT_ONE);

  assign hz1 = iss_use_rs1 & (iss_rs1 != '0) & (cnt[iss_rs1] != '0) & ~byp1;
  assign hz2 = iss_use_rs2 & (iss_rs2 != '0) & (cnt[iss_rs2] != '0) & ~byp2;
  assign sat = iss_wr & (iss_rd != '0) & (cnt[iss_rd] == CNT_MAX);

  assign stall   = iss_valid & (hz1 | hz2 | sat);
  assign inc_any = iss_valid & ~stall & ~flush & iss_wr & (iss_rd != '0);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    obsidian_hazard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .inc   (inc_any & (iss_rd == 5'(r))),
      .dec   (ret & (ret_rd == 5'(r))),
      .cnt   (cnt[r]),
      .busy  (busy_map[r]),
      .err   (err_vec[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_err   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (|err_vec) retire_err <= 1'b1;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: doc/obsidian_hazard_scoreboard.md
Name: obsidian_hazard_scoreboard

Overview:
- Backward-direction control block of the Obsidian 5-stage pipeline (IF, ID, EX, MEM, WB).
- Tracks destination registers of in-flight instructions issued by Decode and retires them from the WB_ID writeback bus.
- Drives a stall back to Fetch/Decode when a source register has a write still pending.
- Turns the forward WB_ID path into the read-after-write interlock that Decode consumes.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is never tracked.
- CNT_W, 2, width of each per-register pending-write counter (max 2^CNT_W-1 in flight).
- WB_BYPASS, 1, when 1 a same-cycle retire of a source register clears its hazard.
- PERF_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iss_valid  input  1  Decode presents an instruction this cycle.
- iss_rs1  input  5  source register 1 index.
- iss_rs2  input  5  source register 2 index.
- iss_use_rs1  input  1  instruction reads rs1.
- iss_use_rs2  input  1  instruction reads rs2.
- iss_wr  input  1  instruction writes a destination register.
- iss_rd  input  5  destination register index.
- WB_ID  input  38  writeback bus: [37] write enable, [36:32] rd, [31:0] data (data ignored here).
- flush  input  1  synchronous clear of all pending state (branch/exception redirect).
- stall  output  1  hold IF_ID and insert a bubble into ID_EX this cycle.
- busy_map  output  NREGS  bit r = 1 when counter r is non-zero.
- retire_err  output  1  sticky: retire seen on a register with zero pending writes.
- stall_cycles  output  PERF_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (rst_n=0, asynchronous): all counters=0, busy_map=0, retire_err=0, stall_cycles=0. stall is combinational and therefore reads 0 while reset is held.
- Source hazard: hz1 = iss_use_rs1 & (rs1!=0) & cnt[rs1]!=0. hz2 is defined the same way for rs2.
- WB_BYPASS=1: a hazard on rs is cleared when this cycle's retire hits rs and cnt[rs]==1.
- Saturation hazard: iss_wr & (rd!=0) & cnt[rd]==max.
- stall = iss_valid & (hz1 | hz2 | saturation hazard). Pure combinational from registered counters and current inputs; zero latency.
- Issue accepted when iss_valid & !stall & !flush. If iss_wr & rd!=0, cnt[rd] increments at the next edge.
- Retire when WB_ID[37] & WB_ID[36:32]!=0:
  - cnt[rd] decrements at the next edge.
  - If cnt[rd]==0, the counter stays 0 and retire_err is set; it clears only on reset.
- Simultaneous accepted issue and retire on the same register: counter unchanged (net 0).
- Issue or retire targeting register 0: no counter change and no error.
- flush=1: all counters cleared at the next edge, overriding issue and retire that cycle.
  - Retires arriving after a flush for pre-flush instructions may set retire_err. Flush is asserted only when MEM/WB hold no valid writes; this is Decode's contract.
- stall_cycles increments on every edge where stall=1 and saturates at all-ones.
- busy_map is a registered function of the counters. It updates one cycle after the triggering issue or retire.
- Reset mid-operation: all state cleared immediately; no pending writes survive.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while driving iss_valid=1, rs1=5 -> stall=0, busy_map=0, stall_cycles=0, retire_err=0.
- RAW interlock:
  - Issue wr rd=3, then next cycle issue with use_rs1, rs1=3 -> stall=1 each cycle until WB_ID={1,3,X}.
  - With WB_BYPASS=1, stall drops in the retire cycle; busy_map[3] returns to 0 one cycle later; stall_cycles equals the number of stalled cycles.
- Register 0: issue wr rd=0, then read rs1=0 and rs2=0 -> stall never asserts; busy_map stays 0.
- Saturation, CNT_W=2: three accepted writes to rd=7 with no retire -> a fourth write to rd=7 stalls. A retire of 7 in the same cycle does not unstall (saturation has no bypass); the next cycle accepts and cnt[7] ends at 3.
- Same-cycle issue+retire: cnt[9]=1, accepted issue wr rd=9 with WB_ID retire rd=9 -> cnt[9]=1, busy_map[9]=1.
- Flush / error:
  - busy regs 2, 4 and flush=1 -> busy_map=0 next cycle.
  - A subsequent WB_ID retire rd=2 -> retire_err=1, which stays 1 until rst_n=0.
  - stall_cycles forced near max for 3 more stall cycles -> holds 16'hFFFF.
